// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable and an optional gate-level cross-check.
// Latency: 1 cycle from sampling en/in to out/valid; one decode per cycle, no bubbles.
// Backpressure: none; every clock edge captures a new result, so there is nothing to stall.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears out, valid and mismatch at once
//   en       decode enable, sampled on the rising edge of clk
//   in       3-bit binary select, sampled with en
//   out      registered one-hot decode of in (8'h00 when the sample was not enabled)
//   valid    registered; high when out holds the decode of an enabled sample
//   mismatch sticky flag set when the gate-level and behavioural decodes disagree
//
// Build option: define DECODER_3TO8_XCHECK_EN to build the gate-level decoder
// next to the behavioural one and compare them on every enabled edge. Without
// it only the behavioural decoder exists and mismatch is a constant 0. out and
// valid behave identically in both builds.

module decoder_3to8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] in,
   output logic [7:0] out,
   output logic       valid,
   output logic       mismatch
);

   // Behavioural decode; this is always the value that reaches out.
   logic [7:0] beh_dec;

   always_comb begin
      beh_dec = 8'h00;
      case (in)
         3'b000:  beh_dec = 8'h01;
         3'b001:  beh_dec = 8'h02;
         3'b010:  beh_dec = 8'h04;
         3'b011:  beh_dec = 8'h08;
         3'b100:  beh_dec = 8'h10;
         3'b101:  beh_dec = 8'h20;
         3'b110:  beh_dec = 8'h40;
         3'b111:  beh_dec = 8'h80;
         // Only reachable with X/Z on in; keeps out all-zero rather than guessing.
         default: beh_dec = 8'h00;
      endcase
   end

   // Output register. A disabled edge clears out as well as valid so that
   // out is never stale: valid=0 always pairs with out=8'h00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= 8'h00;
         valid <= 1'b0;
      end else if (en) begin
         out   <= beh_dec;
         valid <= 1'b1;
      end else begin
         out   <= 8'h00;
         valid <= 1'b0;
      end
   end

`ifdef DECODER_3TO8_XCHECK_EN

   // Gate-level decode: one NOT stage feeding one AND3 per output line.
   // For line k, each literal is the true input bit where k has a 1 and the
   // inverted bit where k has a 0, e.g. line 5 (101) = in2 & ~in1 & in0.
   logic [2:0] in_n;
   logic [7:0] gate_dec;

   assign in_n = ~in;

   for (genvar k = 0; k < 8; k++) begin : g_gate
      localparam logic [2:0] CODE = 3'(k);
      logic lit2;
      logic lit1;
      logic lit0;
      assign lit2        = CODE[2] ? in[2] : in_n[2];
      assign lit1        = CODE[1] ? in[1] : in_n[1];
      assign lit0        = CODE[0] ? in[0] : in_n[0];
      assign gate_dec[k] = lit2 & lit1 & lit0;
   end

   // Sticky disagreement flag; only reset clears it. Disabled edges do not
   // compare, since the decode result is discarded on those edges anyway.
   logic mismatch_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
      end else if (en && (gate_dec != beh_dec)) begin
         mismatch_q <= 1'b1;
      end
   end

   assign mismatch = mismatch_q;

`else

   assign mismatch = 1'b0;

`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: a reference model derived from the
// decoder's rules (1 << code, cleared on disabled edges and on reset) is checked
// every cycle, with hand-written literal expectations at key points.

module tb_decoder_3to8;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] in;
   logic [7:0] out;
   logic       valid;
   logic       mismatch;

   int total;
   int bad;

   decoder_3to8 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in       (in),
      .out      (out),
      .valid    (valid),
      .mismatch (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: next out is the one-hot of the sampled code when enabled,
   // zero otherwise; everything clears immediately on reset.
   logic [7:0] exp_out;
   logic       exp_valid;
   logic       exp_mm;
   logic       force_on;

   initial begin
      exp_out   = 8'h00;
      exp_valid = 1'b0;
      exp_mm    = 1'b0;
      force_on  = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_out   = 8'h00;
         exp_valid = 1'b0;
         exp_mm    = 1'b0;
      end else begin
         exp_out   = en ? (8'd1 << in) : 8'h00;
         exp_valid = en;
         if (en && force_on) exp_mm = 1'b1;
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      chk("model_out", {24'd0, out}, {24'd0, exp_out});
      chk("model_valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("model_mismatch", {31'd0, mismatch}, {31'd0, exp_mm});
      if (valid === 1'b1)
         chk("onehot", $countones(out), 32'd1);
      else
         chk("zero_when_invalid", {24'd0, out}, 32'd0);
   end

   logic [7:0] sweep_exp [8];

   initial begin
      sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      in    = 3'b000;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset_out", {24'd0, out}, 32'h00);
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_mismatch", {31'd0, mismatch}, 32'd0);
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle with en=1, in=101.
      en = 1'b1;
      in = 3'b101;
      @(negedge clk);
      chk("pre_async_out", {24'd0, out}, 32'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out", {24'd0, out}, 32'h00);
      chk("async_rst_valid", {31'd0, valid}, 32'd0);
      chk("async_rst_mismatch", {31'd0, mismatch}, 32'd0);
      @(negedge clk);
      chk("rst_hold_out", {24'd0, out}, 32'h00);
      rst_n = 1'b1;

      // Exhaustive sweep, one code per cycle.
      for (int c = 0; c < 8; c++) begin
         en = 1'b1;
         in = 3'(c);
         @(negedge clk);
         chk("sweep_out", {24'd0, out}, {24'd0, sweep_exp[c]});
         chk("sweep_valid", {31'd0, valid}, 32'd1);
      end

      // Enable gating with in=011 held.
      in = 3'b011;
      en = 1'b1;
      @(negedge clk);
      chk("gate1_out", {24'd0, out}, 32'h08);
      chk("gate1_valid", {31'd0, valid}, 32'd1);
      en = 1'b0;
      @(negedge clk);
      chk("gate0_out", {24'd0, out}, 32'h00);
      chk("gate0_valid", {31'd0, valid}, 32'd0);
      en = 1'b1;
      @(negedge clk);
      chk("gate2_out", {24'd0, out}, 32'h08);
      chk("gate2_valid", {31'd0, valid}, 32'd1);
      @(negedge clk);
      chk("stable_out", {24'd0, out}, 32'h08);

      // Reset mid-stream at code 100, then resume with 110.
      for (int c = 0; c < 5; c++) begin
         in = 3'(c);
         @(negedge clk);
      end
      chk("midstream_pre", {24'd0, out}, 32'h10);
      #2 rst_n = 1'b0;
      #1;
      chk("midstream_clear", {24'd0, out}, 32'h00);
      chk("midstream_valid", {31'd0, valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in    = 3'b110;
      @(negedge clk);
      chk("after_rst_out", {24'd0, out}, 32'h40);
      chk("after_rst_valid", {31'd0, valid}, 32'd1);

      // Random one-hot run; the per-cycle compare does the checking.
      for (int i = 0; i < 1000; i++) begin
         en = 1'b1;
         in = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      for (int i = 0; i < 200; i++) begin
         en = 1'($urandom_range(0, 1));
         in = 3'($urandom_range(0, 7));
         @(negedge clk);
      end

`ifdef DECODER_3TO8_XCHECK_EN
      // Cross-check: corrupt the gate-level decode for one enabled cycle.
      en = 1'b1;
      in = 3'b010;
      force dut.gate_dec = 8'h00;
      force_on = 1'b1;
      @(negedge clk);
      release dut.gate_dec;
      force_on = 1'b0;
      chk("xcheck_set", {31'd0, mismatch}, 32'd1);
      repeat (3) begin
         in = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      chk("xcheck_sticky", {31'd0, mismatch}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("xcheck_clear", {31'd0, mismatch}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("xcheck_after", {31'd0, mismatch}, 32'd0);
`endif

      en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1);
   end

endmodule
